// File: rtl/pool_max.sv
// Streaming signed max-pooling over windows of cfg_len samples, with a
// valid/ready handshake on both sides. Optional macro POOL_MAX_RELU_EN clamps negative results to zero.
module pool_max #(
  parameter int IMG_WIDTH = 16,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [IMG_WIDTH-1:0] up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [IMG_WIDTH-1:0] dn_data,
  output logic                 dn_valid,
  input  logic                 dn_ready
);

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] r_len;
  logic [IMG_WIDTH-1:0] r_max;
  logic [IMG_WIDTH-1:0] r_dn_data;
  logic                 r_dn_valid;

  logic                 w_up_xfer;
  logic                 w_first;
  logic [LEN_WIDTH-1:0] w_len_start;
  logic [LEN_WIDTH-1:0] w_len_cur;
  logic [LEN_WIDTH-1:0] w_cnt_next;
  logic                 w_gt;
  logic [IMG_WIDTH-1:0] w_max_cand;
  logic                 w_done;
  logic [IMG_WIDTH-1:0] w_result;

  // The output register can always absorb a new result when it is empty or draining.
  assign up_ready  = !r_dn_valid || dn_ready;
  assign w_up_xfer = up_valid && up_ready;
  assign w_first   = (r_state == EMPTY);

  assign w_len_start = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
  assign w_len_cur   = w_first ? w_len_start : r_len;
  assign w_cnt_next  = w_first ? LEN_WIDTH'(1) : (r_cnt + LEN_WIDTH'(1));

  // Strictly greater: ties keep the stored maximum.
  assign w_gt       = $signed(up_data) > $signed(r_max);
  assign w_max_cand = (w_first || w_gt) ? up_data : r_max;
  assign w_done     = w_up_xfer && (w_cnt_next == w_len_cur);

`ifdef POOL_MAX_RELU_EN
  assign w_result = w_max_cand[IMG_WIDTH-1] ? '0 : w_max_cand;
`else
  assign w_result = w_max_cand;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_cnt      <= '0;
      r_len      <= LEN_WIDTH'(1);
      r_max      <= '0;
      r_dn_data  <= '0;
      r_dn_valid <= 1'b0;
    end else begin
      if (w_up_xfer) begin
        r_max <= w_max_cand;
        if (w_first) begin
          r_len <= w_len_start;
        end
        if (w_done) begin
          r_cnt   <= '0;
          r_state <= EMPTY;
        end else begin
          r_cnt   <= w_cnt_next;
          r_state <= ACCUM;
        end
      end

      // A completing window wins over a simultaneous drain of the previous result.
      if (w_done) begin
        r_dn_valid <= 1'b1;
        r_dn_data  <= w_result;
      end else if (r_dn_valid && dn_ready) begin
        r_dn_valid <= 1'b0;
      end
    end
  end

  assign dn_data  = r_dn_data;
  assign dn_valid = r_dn_valid;

endmodule

// File: tb/tb_pool_max.sv
// Bench for pool_max: a queue-based window model checked against the DUT every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_pool_max;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cfg_len;
  logic [15:0] up_data;
  logic        up_valid;
  logic        up_ready;
  logic [15:0] dn_data;
  logic        dn_valid;
  logic        dn_ready;

  pool_max #(.IMG_WIDTH(16), .LEN_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_len  (cfg_len),
    .up_data  (up_data),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .dn_data  (dn_data),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef POOL_MAX_RELU_EN
  localparam logic [15:0] EXP_NEG20 = 16'h0000;
  localparam logic [15:0] EXP_8000  = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG20 = 16'hFFEC;
  localparam logic [15:0] EXP_8000  = 16'h8000;
`endif

  // Reference model: current window as a queue, output slot as valid/data.
  logic signed [15:0] win[$];
  int                 m_len;
  logic               m_valid;
  logic [15:0]        m_data;
  logic               m_in_xfer;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.delete();
      m_len     = 1;
      m_valid   = 1'b0;
      m_data    = 16'h0000;
      m_in_xfer = 1'b0;
    end else begin
      logic               in_x;
      logic               out_x;
      logic               done;
      logic signed [15:0] res;
      in_x = up_valid && (!m_valid || dn_ready);
      out_x = m_valid && dn_ready;
      done = 1'b0;
      res = 16'sd0;
      if (in_x) begin
        if (win.size() == 0) m_len = (cfg_len == 4'd0) ? 1 : int'(cfg_len);
        win.push_back($signed(up_data));
        if (win.size() == m_len) begin
          res = win[0];
          foreach (win[k]) if (win[k] > res) res = win[k];
`ifdef POOL_MAX_RELU_EN
          if (res < 0) res = 16'sd0;
`endif
          done = 1'b1;
          win.delete();
        end
      end
      if (done) begin
        m_valid = 1'b1;
        m_data  = res;
      end else if (out_x) begin
        m_valid = 1'b0;
      end
      m_in_xfer = in_x;
    end
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, then compare DUT outputs against the model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("dn_valid", 32'(dn_valid), 32'(m_valid));
    if (m_valid || !rst_n) chk("dn_data", 32'(dn_data), 32'(m_data));
    chk("up_ready", 32'(up_ready), 32'(!m_valid || dn_ready));
  endtask

  task automatic send(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    up_valid = 1'b1;
    up_data  = d;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m_in_xfer) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    $display("send %04h cfg_len=%0d dn_valid=%0b dn_data=%04h", d, cfg_len, dn_valid, dn_data);
  endtask

  task automatic idle();
    up_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    cfg_len  = 4'd4;
    up_data  = 16'h0;
    up_valid = 1'b0;
    dn_ready = 1'b1;
    tick();
    tick();
    chk("reset_dn_valid", 32'(dn_valid), 32'd0);
    chk("reset_dn_data", 32'(dn_data), 32'd0);
    chk("reset_up_ready", 32'(up_ready), 32'd1);
    rst_n = 1'b1;

    // Window of 4: max 12, appearing one cycle after the last sample.
    send(16'd3);
    send(16'hFFF9);
    send(16'd12);
    chk("w4_not_yet", 32'(dn_valid), 32'd0);
    send(16'd5);
    chk("w4_valid", 32'(dn_valid), 32'd1);
    chk("w4_data", 32'(dn_data), 32'd12);
    idle();
    chk("w4_single_pulse", 32'(dn_valid), 32'd0);

    // All-negative window of 2.
    cfg_len = 4'd2;
    send(16'hFED4);
    send(16'hFFEC);
    chk("neg_data", 32'(dn_data), 32'(EXP_NEG20));
    idle();

    // Pass-through at extremes, one result per cycle.
    cfg_len = 4'd1;
    send(16'h7FFF);
    chk("pt0", 32'(dn_data), 32'h7FFF);
    send(16'h8000);
    chk("pt1", 32'(dn_data), 32'(EXP_8000));
    send(16'h0001);
    chk("pt2", 32'(dn_data), 32'h0001);
    chk("pt2_valid", 32'(dn_valid), 32'd1);
    idle();

    // Back-pressure: result held, input blocked until dn_ready returns.
    cfg_len  = 4'd2;
    dn_ready = 1'b0;
    send(16'd10);
    send(16'd20);
    chk("bp_first", 32'(dn_data), 32'd20);
    up_valid = 1'b1;
    up_data  = 16'd30;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_valid", 32'(dn_valid), 32'd1);
      chk("bp_hold_data", 32'(dn_data), 32'd20);
      chk("bp_blocked", 32'(up_ready), 32'd0);
    end
    dn_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(dn_valid), 32'd0);
    send(16'd40);
    chk("bp_second", 32'(dn_data), 32'd40);
    idle();

    // cfg_len change mid-window applies only at the next window.
    cfg_len = 4'd3;
    send(16'd1);
    cfg_len = 4'd2;
    send(16'd9);
    chk("len_mid", 32'(dn_valid), 32'd0);
    send(16'd4);
    chk("len_old", 32'(dn_data), 32'd9);
    send(16'd2);
    chk("len_new_partial", 32'(dn_valid), 32'd0);
    send(16'd7);
    chk("len_new", 32'(dn_data), 32'd7);
    idle();

    // Reset with a pending result drops it.
    dn_ready = 1'b0;
    send(16'd77);
    send(16'd88);
    up_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", 32'(dn_valid), 32'd0);
    chk("rst_drop_ready", 32'(up_ready), 32'd1);
    dn_ready = 1'b1;
    tick();
    rst_n = 1'b1;

    // Reset mid-window discards the partial samples.
    cfg_len = 4'd4;
    send(16'd100);
    send(16'd200);
    up_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(dn_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    send(16'd10);
    send(16'd30);
    send(16'd20);
    send(16'd5);
    chk("rst_mid_result", 32'(dn_data), 32'd30);
    idle();

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      up_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       up_data = 16'h7FFF;
        1:       up_data = 16'h8000;
        2:       up_data = 16'h0000;
        3:       up_data = 16'hFFFF;
        default: up_data = 16'($urandom);
      endcase
      dn_ready = (i % 400 < 100) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) cfg_len = 4'($urandom_range(0, 15));
      tick();
      if (dn_valid && dn_ready) $display("rand out %04h", dn_data);
    end
    rst_n    = 1'b1;
    up_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
